// File: rtl/lighting_pkg.sv
// Shared types, default parameters and helpers for the multi-zone lighting controller.
package lighting_pkg;

    typedef enum logic [2:0] {
        AUTO_OFF  = 3'd0,
        AUTO_ON   = 3'd1,
        AUTO_WARN = 3'd2,
        MAN_ON    = 3'd3,
        MAN_OFF   = 3'd4
    } zone_state_t;

    localparam int unsigned N_ZONES_DEF      = 4;
    localparam int unsigned DEBOUNCE_CYC_DEF = 16;
    localparam int unsigned HOLD_CYC_DEF     = 3000;
    localparam int unsigned WARN_CYC_DEF     = 500;
    localparam int unsigned PWM_W_DEF        = 4;
    localparam int unsigned DIM_DUTY_DEF     = 4;

    // Bits needed for a hold timer that counts down from hold_cyc to 0
    function automatic int unsigned timer_width(input int unsigned hold_cyc);
        return 32'($clog2(hold_cyc + 1));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser and debouncer; emits a one-cycle pulse on a debounced rising edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Two-flop synchroniser; reset high so a button held through reset looks stable
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Count cycles of disagreement; accept the new level after DEBOUNCE_CYC of them
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state; debounced level starts high so no press fires until a release is seen
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/lighting_zone_ctrl.sv
// Multi-zone lighting controller: per-zone auto/manual FSM with hold timer and dimmed warning.
module lighting_zone_ctrl
    import lighting_pkg::*;
#(
    parameter int unsigned N_ZONES      = N_ZONES_DEF,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned HOLD_CYC     = HOLD_CYC_DEF,
    parameter int unsigned WARN_CYC     = WARN_CYC_DEF,
    parameter int unsigned PWM_W        = PWM_W_DEF,
    parameter int unsigned DIM_DUTY     = DIM_DUTY_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ZONES-1:0] push_button,
    input  logic [N_ZONES-1:0] infravermelho,
    output logic [N_ZONES-1:0] led,
    output logic [N_ZONES-1:0] saida,
    output logic               any_on
);

    localparam int unsigned TMR_W = timer_width(HOLD_CYC);

    if ((WARN_CYC == 0) || (WARN_CYC >= HOLD_CYC)) begin : g_bad_warn
        $error("lighting_zone_ctrl: WARN_CYC must satisfy 0 < WARN_CYC < HOLD_CYC");
    end
    if (DIM_DUTY >= (32'd1 << PWM_W)) begin : g_bad_duty
        $error("lighting_zone_ctrl: DIM_DUTY must be below 2**PWM_W");
    end

    logic [PWM_W-1:0] pwm_q;
    logic [PWM_W-1:0] pwm_d;
    logic             dim_on;
    logic             any_on_q;

    assign pwm_d  = pwm_q + PWM_W'(1);
    assign dim_on = (pwm_d < PWM_W'(DIM_DUTY));

    // Shared free-running dimming counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        logic             pir_s1_q;
        logic             pir_s2_q;
        logic             press;
        zone_state_t      state_q;
        zone_state_t      state_d;
        logic [TMR_W-1:0] timer_q;
        logic [TMR_W-1:0] timer_d;
        logic [TMR_W-1:0] timer_dec;
        logic             saida_q;
        logic             saida_d;
        logic             led_q;
        logic             led_d;

        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_btn (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (push_button[z]),
            .press_o (press)
        );

        // PIR synchroniser; motion is not debounced
        always_ff @(posedge clk) begin
            if (rst) begin
                pir_s1_q <= 1'b0;
                pir_s2_q <= 1'b0;
            end else begin
                pir_s1_q <= infravermelho[z];
                pir_s2_q <= pir_s1_q;
            end
        end

        assign timer_dec = (timer_q == '0) ? '0 : timer_q - TMR_W'(1);

        // Next state, hold timer and output decode; a press outranks PIR
        always_comb begin
            state_d = state_q;
            timer_d = '0;
            saida_d = 1'b0;
            led_d   = 1'b0;
            case (state_q)
                AUTO_OFF: begin
                    if (press) begin
                        state_d = MAN_ON;
                    end else if (pir_s2_q) begin
                        state_d = AUTO_ON;
                        timer_d = TMR_W'(HOLD_CYC);
                    end
                end
                AUTO_ON: begin
                    if (press) begin
                        state_d = MAN_ON;
                    end else if (pir_s2_q) begin
                        timer_d = TMR_W'(HOLD_CYC);
                    end else begin
                        timer_d = timer_dec;
                        if (timer_q == TMR_W'(WARN_CYC)) begin
                            state_d = AUTO_WARN;
                        end
                    end
                end
                AUTO_WARN: begin
                    if (press) begin
                        state_d = MAN_ON;
                    end else if (pir_s2_q) begin
                        state_d = AUTO_ON;
                        timer_d = TMR_W'(HOLD_CYC);
                    end else if (timer_q == '0) begin
                        state_d = AUTO_OFF;
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                MAN_ON: begin
                    if (press) begin
                        state_d = MAN_OFF;
                    end
                end
                MAN_OFF: begin
                    if (press) begin
                        state_d = AUTO_OFF;
                    end
                end
                default: begin
                    state_d = AUTO_OFF;
                end
            endcase

            case (state_d)
                AUTO_ON, MAN_ON: saida_d = 1'b1;
                AUTO_WARN:       saida_d = dim_on;
                default:         saida_d = 1'b0;
            endcase
            led_d = (state_d == MAN_ON) || (state_d == MAN_OFF);
        end

        // Zone state, timer and registered lamp/indicator outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= AUTO_OFF;
                timer_q <= '0;
                saida_q <= 1'b0;
                led_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                saida_q <= saida_d;
                led_q   <= led_d;
            end
        end

        assign saida[z] = saida_q;
        assign led[z]   = led_q;
    end

    // Any-lamp-on summary, one cycle behind the lamp outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            any_on_q <= 1'b0;
        end else begin
            any_on_q <= |saida;
        end
    end

    assign any_on = any_on_q;

endmodule

// File: tb/tb_lighting_zone_ctrl.sv
// Scenario bench for lighting_zone_ctrl with a per-cycle expectation scoreboard.
module tb_lighting_zone_ctrl;

    localparam int NZ   = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 40;
    localparam int WARN = 10;
    localparam int PW   = 2;
    localparam int DUTY = 1;

    localparam int K_OFF = 0;
    localparam int K_ON  = 1;
    localparam int K_DIM = 2;

    typedef struct {
        int         k;
        int         k0;
        int         k1;
        logic [1:0] led;
        bit         arst;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NZ-1:0] push_button;
    logic [NZ-1:0] infravermelho;
    logic [NZ-1:0] led;
    logic [NZ-1:0] saida;
    logic          any_on;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   ecount   = 0;
    bit   prev_valid = 1'b0;
    logic prev_or    = 1'b0;

    lighting_zone_ctrl #(
        .N_ZONES      (NZ),
        .DEBOUNCE_CYC (DEB),
        .HOLD_CYC     (HOLD),
        .WARN_CYC     (WARN),
        .PWM_W        (PW),
        .DIM_DUTY     (DUTY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push_button   (push_button),
        .infravermelho (infravermelho),
        .led           (led),
        .saida         (saida),
        .any_on        (any_on)
    );

    always #5 clk = ~clk;

    // Edges since reset released: the free-running PWM phase seen by the outputs
    always @(posedge clk) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    function automatic logic kbit(input int kind);
        if (kind == K_ON)  return 1'b1;
        if (kind == K_DIM) return ((ecount % (1 << PW)) < DUTY);
        return 1'b0;
    endfunction

    function automatic exp_t mk(input int k, input int k0, input int k1, input logic [1:0] l, input bit a);
        exp_t e;
        e.k = k; e.k0 = k0; e.k1 = k1; e.led = l; e.arst = a;
        return e;
    endfunction

    // Auto-mode lamp: on from on_from, dimmed after HOLD-WARN cycles past the last PIR sample, off after HOLD
    function automatic int auto_kind(input int k, input int on_from, input int last);
        if (k < on_from) return K_OFF;
        if (k <= last + HOLD - WARN) return K_ON;
        if (k <= last + HOLD) return K_DIM;
        return K_OFF;
    endfunction

    task automatic drive(input logic [1:0] p, input logic [1:0] b, input logic r, input exp_t e);
        infravermelho = p;
        push_button   = b;
        rst           = r;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        exp_t e; logic [1:0] es; logic ea;
        rst = 1'b1; push_button = '0; infravermelho = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (saida !== 2'b00) begin failures++; $display("FAIL reset saida got=%b exp=00", saida); end
        checks++; if (led !== 2'b00) begin failures++; $display("FAIL reset led got=%b exp=00", led); end
        checks++; if (any_on !== 1'b0) begin failures++; $display("FAIL reset any_on got=%b exp=0", any_on); end
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); es = {kbit(e.k1), kbit(e.k0)};
                checks++; if (saida !== es) begin failures++; $display("FAIL idle saida k=%0d got=%b exp=%b", e.k, saida, es); end
                checks++; if (led !== e.led) begin failures++; $display("FAIL idle led k=%0d got=%b exp=%b", e.k, led, e.led); end
                if (prev_valid) begin
                    ea = e.arst ? 1'b0 : prev_or;
                    checks++; if (any_on !== ea) begin failures++; $display("FAIL idle any_on k=%0d got=%b exp=%b", e.k, any_on, ea); end
                end
                prev_or = |es; prev_valid = 1'b1;
            end else prev_valid = 1'b0;
            if (k <= 12) begin #1; drive(2'b00, 2'b00, 1'b0, mk(k, K_OFF, K_OFF, 2'b00, 1'b0)); end
        end
    endtask

    task automatic test_auto;
        exp_t e; logic [1:0] es; logic ea;
        for (int k = 1; k <= 53; k++) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); es = {kbit(e.k1), kbit(e.k0)};
                checks++; if (saida !== es) begin failures++; $display("FAIL auto saida k=%0d got=%b exp=%b", e.k, saida, es); end
                checks++; if (led !== e.led) begin failures++; $display("FAIL auto led k=%0d got=%b exp=%b", e.k, led, e.led); end
                if (prev_valid) begin
                    ea = e.arst ? 1'b0 : prev_or;
                    checks++; if (any_on !== ea) begin failures++; $display("FAIL auto any_on k=%0d got=%b exp=%b", e.k, any_on, ea); end
                end
                prev_or = |es; prev_valid = 1'b1;
            end else prev_valid = 1'b0;
            if (k <= 52) begin
                #1;
                drive({1'b0, (k <= 5)}, 2'b00, 1'b0, mk(k, auto_kind(k, 3, 7), K_OFF, 2'b00, 1'b0));
            end
        end
    endtask

    task automatic test_retrigger;
        exp_t e; logic [1:0] es; logic ea; int k0;
        for (int k = 1; k <= 85; k++) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); es = {kbit(e.k1), kbit(e.k0)};
                checks++; if (saida !== es) begin failures++; $display("FAIL retrigger saida k=%0d got=%b exp=%b", e.k, saida, es); end
                checks++; if (led !== e.led) begin failures++; $display("FAIL retrigger led k=%0d got=%b exp=%b", e.k, led, e.led); end
                if (prev_valid) begin
                    ea = e.arst ? 1'b0 : prev_or;
                    checks++; if (any_on !== ea) begin failures++; $display("FAIL retrigger any_on k=%0d got=%b exp=%b", e.k, any_on, ea); end
                end
                prev_or = |es; prev_valid = 1'b1;
            end else prev_valid = 1'b0;
            if (k <= 84) begin
                #1;
                k0 = (k < 38) ? auto_kind(k, 3, 3) : auto_kind(k, 38, 38);
                drive({1'b0, (k == 1) || (k == 36)}, 2'b00, 1'b0, mk(k, k0, K_OFF, 2'b00, 1'b0));
            end
        end
    endtask

    task automatic test_manual;
        exp_t e; logic [1:0] es; logic ea; logic b1; logic p1; int k1; logic l1;
        for (int k = 1; k <= 61; k++) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); es = {kbit(e.k1), kbit(e.k0)};
                checks++; if (saida !== es) begin failures++; $display("FAIL manual saida k=%0d got=%b exp=%b", e.k, saida, es); end
                checks++; if (led !== e.led) begin failures++; $display("FAIL manual led k=%0d got=%b exp=%b", e.k, led, e.led); end
                if (prev_valid) begin
                    ea = e.arst ? 1'b0 : prev_or;
                    checks++; if (any_on !== ea) begin failures++; $display("FAIL manual any_on k=%0d got=%b exp=%b", e.k, any_on, ea); end
                end
                prev_or = |es; prev_valid = 1'b1;
            end else prev_valid = 1'b0;
            if (k <= 60) begin
                #1;
                b1 = (k <= 10) || (k >= 20 && k <= 29) || (k >= 40 && k <= 49);
                p1 = (k >= 12 && k <= 16) || (k >= 30 && k <= 36);
                k1 = (k >= 7 && k <= 25) ? K_ON : K_OFF;
                l1 = (k >= 7 && k <= 45);
                drive({p1, 1'b0}, {b1, 1'b0}, 1'b0, mk(k, K_OFF, k1, {l1, 1'b0}, 1'b0));
            end
        end
    endtask

    task automatic test_debounce;
        exp_t e; logic [1:0] es; logic ea; logic b0; int k0; logic l0;
        for (int k = 1; k <= 61; k++) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); es = {kbit(e.k1), kbit(e.k0)};
                checks++; if (saida !== es) begin failures++; $display("FAIL debounce saida k=%0d got=%b exp=%b", e.k, saida, es); end
                checks++; if (led !== e.led) begin failures++; $display("FAIL debounce led k=%0d got=%b exp=%b", e.k, led, e.led); end
                if (prev_valid) begin
                    ea = e.arst ? 1'b0 : prev_or;
                    checks++; if (any_on !== ea) begin failures++; $display("FAIL debounce any_on k=%0d got=%b exp=%b", e.k, any_on, ea); end
                end
                prev_or = |es; prev_valid = 1'b1;
            end else prev_valid = 1'b0;
            if (k <= 60) begin
                #1;
                b0 = (k <= 3) || (k >= 10 && k <= 13) || (k >= 30 && k <= 35) || (k >= 45 && k <= 50);
                k0 = (k >= 16 && k <= 35) ? K_ON : K_OFF;
                l0 = (k >= 16 && k <= 50);
                drive(2'b00, {1'b0, b0}, 1'b0, mk(k, k0, K_OFF, {1'b0, l0}, 1'b0));
            end
        end
    endtask

    task automatic test_simultaneous;
        exp_t e; logic [1:0] es; logic ea; logic b0; int k0; logic l0;
        for (int k = 1; k <= 51; k++) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); es = {kbit(e.k1), kbit(e.k0)};
                checks++; if (saida !== es) begin failures++; $display("FAIL simultaneous saida k=%0d got=%b exp=%b", e.k, saida, es); end
                checks++; if (led !== e.led) begin failures++; $display("FAIL simultaneous led k=%0d got=%b exp=%b", e.k, led, e.led); end
                if (prev_valid) begin
                    ea = e.arst ? 1'b0 : prev_or;
                    checks++; if (any_on !== ea) begin failures++; $display("FAIL simultaneous any_on k=%0d got=%b exp=%b", e.k, any_on, ea); end
                end
                prev_or = |es; prev_valid = 1'b1;
            end else prev_valid = 1'b0;
            if (k <= 50) begin
                #1;
                b0 = (k <= 10) || (k >= 20 && k <= 25) || (k >= 35 && k <= 40);
                k0 = (k >= 7 && k <= 25) ? K_ON : K_OFF;
                l0 = (k >= 7 && k <= 40);
                drive({1'b0, (k == 5)}, {1'b0, b0}, 1'b0, mk(k, k0, K_OFF, {1'b0, l0}, 1'b0));
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e; logic [1:0] es; logic ea; logic b1; logic r; int k0; int k1; logic l1;
        for (int k = 1; k <= 53; k++) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); es = {kbit(e.k1), kbit(e.k0)};
                checks++; if (saida !== es) begin failures++; $display("FAIL reset_mid saida k=%0d got=%b exp=%b", e.k, saida, es); end
                checks++; if (led !== e.led) begin failures++; $display("FAIL reset_mid led k=%0d got=%b exp=%b", e.k, led, e.led); end
                if (prev_valid) begin
                    ea = e.arst ? 1'b0 : prev_or;
                    checks++; if (any_on !== ea) begin failures++; $display("FAIL reset_mid any_on k=%0d got=%b exp=%b", e.k, any_on, ea); end
                end
                prev_or = |es; prev_valid = 1'b1;
            end else prev_valid = 1'b0;
            if (k <= 52) begin
                #1;
                r  = (k == 15) || (k == 16);
                b1 = (k <= 30) || (k >= 40 && k <= 50);
                k0 = (k >= 3 && k <= 14) ? K_ON : K_OFF;
                k1 = ((k >= 7 && k <= 14) || k >= 46) ? K_ON : K_OFF;
                l1 = (k >= 7 && k <= 14) || (k >= 46);
                drive({1'b0, (k == 1)}, {b1, 1'b0}, r, mk(k, k0, k1, {l1, 1'b0}, r));
            end
        end
    endtask

    initial begin
        test_reset;
        test_auto;
        test_retrigger;
        test_manual;
        test_debounce;
        test_simultaneous;
        test_reset_mid;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
